// File: rtl/matrix_loader_pkg.sv
// Shared constants, order codes and FSM state type for the matrix loader.
package matrix_loader_pkg;

  localparam int unsigned ELEM_W = 8;
  localparam int unsigned MAX_N  = 5;
  localparam int unsigned MAT_W  = MAX_N * MAX_N * ELEM_W;  // 200
  localparam int unsigned CNT_W  = 5;                       // holds up to 25 elements

  localparam logic [1:0] ORD_2X2 = 2'b00;
  localparam logic [1:0] ORD_3X3 = 2'b01;
  localparam logic [1:0] ORD_4X4 = 2'b10;
  localparam logic [1:0] ORD_5X5 = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StPresent
  } state_e;

  // Number of elements n*n for an order code, n = code + 2.
  function automatic logic [CNT_W-1:0] num_elems(input logic [1:0] code);
    logic [CNT_W-1:0] n;
    unique case (code)
      ORD_2X2: n = CNT_W'(4);
      ORD_3X3: n = CNT_W'(9);
      ORD_4X4: n = CNT_W'(16);
      default: n = CNT_W'(25);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/matrix_loader.sv
// Streams signed elements (row-major) into a packed matrix for the determinant
// unit, then presents it with a valid/ack handshake.
// Optional feature: define MATRIX_LOADER_DET_CAPTURE_EN to add det/det_out/det_valid,
// which register the determinant result when the presented matrix is acknowledged.
module matrix_loader #(
  parameter int unsigned ELEM_W = matrix_loader_pkg::ELEM_W,
  parameter int unsigned MAX_N  = matrix_loader_pkg::MAX_N
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [1:0]                      tamanho,
  input  logic                            abort,
  input  logic signed [ELEM_W-1:0]        dado,
  input  logic                            dado_valid,
  output logic                            dado_ready,
  output logic [MAX_N*MAX_N*ELEM_W-1:0]   matriz,
  output logic [1:0]                      sinalizador,
  output logic                            matriz_valid,
  input  logic                            matriz_ack,
`ifdef MATRIX_LOADER_DET_CAPTURE_EN
  input  logic signed [31:0]              det,
  output logic signed [31:0]              det_out,
  output logic                            det_valid,
`endif
  output logic                            busy
);

  import matrix_loader_pkg::*;

  localparam int unsigned NSLOT = MAX_N * MAX_N;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NSLOT*ELEM_W-1:0]   matriz_q, matriz_d;
  logic [1:0]                sinal_q, sinal_d;
  logic [CNT_W-1:0]          nelem;
  logic [CNT_W-1:0]          slot;
  logic                      last;

  // Transfer k lands in element slot N-1-k, so the first element ends up on top.
  assign nelem = num_elems(sinal_q);
  assign slot  = nelem - CNT_W'(1) - cnt_q;
  assign last  = (cnt_q == nelem - CNT_W'(1));

  // State, counter and matrix registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      matriz_q <= '0;
      sinal_q  <= ORD_2X2;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      matriz_q <= matriz_d;
      sinal_q  <= sinal_d;
    end
  end

  // Next-state and datapath updates; abort always takes priority.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    matriz_d = matriz_q;
    sinal_d  = sinal_q;
    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d  = StLoad;
          sinal_d  = tamanho;
          matriz_d = '0;
          cnt_d    = '0;
        end
      end
      StLoad: begin
        if (abort) begin
          state_d  = StIdle;
          matriz_d = '0;
          cnt_d    = '0;
        end else if (dado_valid) begin
          for (int e = 0; e < int'(NSLOT); e++) begin
            if (slot == CNT_W'(e)) matriz_d[e*ELEM_W +: ELEM_W] = dado;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (last) state_d = StPresent;
        end
      end
      StPresent: begin
        if (abort) begin
          state_d  = StIdle;
          matriz_d = '0;
        end else if (matriz_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake flags decode straight from the state register.
  always_comb begin
    dado_ready   = (state_q == StLoad);
    matriz_valid = (state_q == StPresent);
    busy         = (state_q != StIdle);
    matriz       = matriz_q;
    sinalizador  = sinal_q;
  end

`ifdef MATRIX_LOADER_DET_CAPTURE_EN
  logic               cap;
  logic signed [31:0] det_out_q;
  logic               det_valid_q;

  assign cap = (state_q == StPresent) && matriz_ack && !abort;

  // Capture the determinant on a clean acknowledge; det_valid is a one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      det_out_q   <= '0;
      det_valid_q <= 1'b0;
    end else begin
      det_valid_q <= cap;
      if (cap) det_out_q <= det;
    end
  end

  assign det_out   = det_out_q;
  assign det_valid = det_valid_q;
`endif

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: table-driven loads plus hand-written
// abort, reset and ignored-input sequences; a scoreboard queue checks every
// presented matrix. Optional det capture checks run when
// MATRIX_LOADER_DET_CAPTURE_EN is defined.
module tb_matrix_loader;

  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   tamanho;
  logic         abort;
  logic signed [7:0] dado;
  logic         dado_valid;
  logic         dado_ready;
  logic [199:0] matriz;
  logic [1:0]   sinalizador;
  logic         matriz_valid;
  logic         matriz_ack;
  logic         busy;
`ifdef MATRIX_LOADER_DET_CAPTURE_EN
  logic signed [31:0] det;
  logic signed [31:0] det_out;
  logic               det_valid;
`endif

  matrix_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .tamanho      (tamanho),
    .abort        (abort),
    .dado         (dado),
    .dado_valid   (dado_valid),
    .dado_ready   (dado_ready),
    .matriz       (matriz),
    .sinalizador  (sinalizador),
    .matriz_valid (matriz_valid),
    .matriz_ack   (matriz_ack),
`ifdef MATRIX_LOADER_DET_CAPTURE_EN
    .det          (det),
    .det_out      (det_out),
    .det_valid    (det_valid),
`endif
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [1:0]   tam;
    logic [1:0]   kind;  // element generator: 0 list2, 1 list3, 2 k+1, 3 0x80+k
    logic [1:0]   gap;   // idle cycles before each transfer
    logic [199:0] exp;
  } vec_t;

  typedef struct packed {
    logic [1:0]   tam;
    logic [199:0] mat;
  } sb_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  sb_t  exp_q[$];
  logic prev_v;
  vec_t vecs[4];
  int   l2[4] = '{3, -2, 4, -1};
  int   l3[9] = '{6, -1, 3, 4, -2, 5, 9, 0, -6};

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] elem(input logic [1:0] kind, input int k);
    case (kind)
      2'd0:    return 8'(l2[k]);
      2'd1:    return 8'(l3[k]);
      2'd2:    return 8'(k + 1);
      default: return 8'(128 + k);
    endcase
  endfunction

  // Scoreboard: each rising matriz_valid must match the oldest pending load.
  always @(negedge clk) begin
    if (!rst && matriz_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: matriz_valid rose with no load pending, matriz=%0h", matriz);
      end else begin
        sb_t e;
        e = exp_q.pop_front();
        check("sb_matriz", matriz, e.mat);
        check("sb_sinal", {198'd0, sinalizador}, {198'd0, e.tam});
      end
    end
    prev_v <= matriz_valid;
  end

  task automatic run_vec(input vec_t v, input int idx);
    int  n;
    sb_t e;
    n = (int'(v.tam) + 2) * (int'(v.tam) + 2);
    start   = 1'b1;
    tamanho = v.tam;
    tick();
    start   = 1'b0;
    tamanho = ~v.tam;
    check("load_busy", {199'd0, busy}, 200'd1);
    check("load_ready", {199'd0, dado_ready}, 200'd1);
    check("load_clear", matriz, 200'd0);
    e.tam = v.tam;
    e.mat = v.exp;
    exp_q.push_back(e);
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < int'(v.gap); g++) begin
        dado_valid = 1'b0;
        dado       = 8'hA5;
        tick();
      end
      dado_valid = 1'b1;
      dado       = elem(v.kind, k);
      tick();
      if (k < n - 1) check("valid_early", {199'd0, matriz_valid}, 200'd0);
    end
    dado_valid = 1'b0;
    check("valid_latency", {199'd0, matriz_valid}, 200'd1);
    check("present_ready", {199'd0, dado_ready}, 200'd0);
    tick();
    check("present_hold_valid", {199'd0, matriz_valid}, 200'd1);
    check("present_hold_mat", matriz, v.exp);
`ifdef MATRIX_LOADER_DET_CAPTURE_EN
    det = 32'sd57 + idx;
`endif
    matriz_ack = 1'b1;
    tick();
    matriz_ack = 1'b0;
    check("ack_valid_low", {199'd0, matriz_valid}, 200'd0);
    check("ack_idle", {199'd0, busy}, 200'd0);
    check("idle_hold_mat", matriz, v.exp);
    check("idle_hold_sinal", {198'd0, sinalizador}, {198'd0, v.tam});
`ifdef MATRIX_LOADER_DET_CAPTURE_EN
    check("det_valid_pulse", {199'd0, det_valid}, 200'd1);
    check("det_out", {168'd0, det_out}, {168'd0, 32'sd57 + 32'(idx)});
    det = -32'sd1;
    tick();
    check("det_valid_end", {199'd0, det_valid}, 200'd0);
    check("det_out_hold", {168'd0, det_out}, {168'd0, 32'sd57 + 32'(idx)});
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sb_t e;
    vecs[0] = '{tam: 2'b00, kind: 2'd0, gap: 2'd0, exp: 200'h03FE04FF};
    vecs[1] = '{tam: 2'b01, kind: 2'd1, gap: 2'd1, exp: 200'h06FF0304FE050900FA};
    vecs[2] = '{tam: 2'b11, kind: 2'd2, gap: 2'd0,
                exp: 200'h0102030405060708090A0B0C0D0E0F10111213141516171819};
    vecs[3] = '{tam: 2'b10, kind: 2'd3, gap: 2'd2,
                exp: 200'h808182838485868788898A8B8C8D8E8F};

    rst = 1'b1; start = 1'b0; tamanho = 2'b00; abort = 1'b0;
    dado = '0; dado_valid = 1'b0; matriz_ack = 1'b0;
`ifdef MATRIX_LOADER_DET_CAPTURE_EN
    det = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_matriz", matriz, 200'd0);
    check("rst_sinal", {198'd0, sinalizador}, 200'd0);
    check("rst_valid", {199'd0, matriz_valid}, 200'd0);
    check("rst_ready", {199'd0, dado_ready}, 200'd0);
    check("rst_busy", {199'd0, busy}, 200'd0);
    rst = 1'b0;  // start is driven in this same cycle: first edge must accept it

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // dado_valid in IDLE is ignored
    dado_valid = 1'b1;
    dado       = 8'h55;
    tick();
    tick();
    dado_valid = 1'b0;
    check("idle_ignore_mat", matriz, vecs[3].exp);
    check("idle_ignore_ready", {199'd0, dado_ready}, 200'd0);

    // start together with abort in IDLE is ignored
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort_start", {199'd0, busy}, 200'd0);
    check("idle_abort_mat", matriz, vecs[3].exp);

    // abort in LOAD after two transfers
    start   = 1'b1;
    tamanho = 2'b10;
    tick();
    start      = 1'b0;
    dado_valid = 1'b1;
    dado       = 8'sd7;
    tick();
    dado = 8'sd8;
    tick();
    abort = 1'b1;
    dado  = 8'sd9;
    tick();
    abort      = 1'b0;
    dado_valid = 1'b0;
    check("abort_load_busy", {199'd0, busy}, 200'd0);
    check("abort_load_mat", matriz, 200'd0);
    check("abort_load_valid", {199'd0, matriz_valid}, 200'd0);
    repeat (3) tick();
    check("abort_load_stays", {199'd0, matriz_valid}, 200'd0);

    // start/tamanho during LOAD ignored, then abort+ack together in PRESENT
    start   = 1'b1;
    tamanho = 2'b00;
    tick();
    start = 1'b0;
    e.tam = 2'b00;
    e.mat = 200'h01020304;
    exp_q.push_back(e);
    dado_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dado = 8'(k + 1);
      if (k == 2) begin
        start   = 1'b1;
        tamanho = 2'b11;
      end
      tick();
      start = 1'b0;
    end
    dado_valid = 1'b0;
    check("relaunch_valid", {199'd0, matriz_valid}, 200'd1);
    check("relaunch_sinal", {198'd0, sinalizador}, 200'd0);
    check("relaunch_mat", matriz, 200'h01020304);
    tick();
    matriz_ack = 1'b1;
    abort      = 1'b1;
    tick();
    matriz_ack = 1'b0;
    abort      = 1'b0;
    check("abort_ack_busy", {199'd0, busy}, 200'd0);
    check("abort_ack_mat", matriz, 200'd0);
    check("abort_ack_valid", {199'd0, matriz_valid}, 200'd0);
`ifdef MATRIX_LOADER_DET_CAPTURE_EN
    check("abort_ack_det_valid", {199'd0, det_valid}, 200'd0);
`endif

    // asynchronous reset while presenting a 3x3
    start   = 1'b1;
    tamanho = 2'b01;
    tick();
    start = 1'b0;
    e.tam = 2'b01;
    e.mat = 200'h010203040506070809;
    exp_q.push_back(e);
    dado_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      dado = 8'(k + 1);
      tick();
    end
    dado_valid = 1'b0;
    check("pre_rst_valid", {199'd0, matriz_valid}, 200'd1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_matriz", matriz, 200'd0);
    check("async_rst_sinal", {198'd0, sinalizador}, 200'd0);
    check("async_rst_valid", {199'd0, matriz_valid}, 200'd0);
    check("async_rst_ready", {199'd0, dado_ready}, 200'd0);
    check("async_rst_busy", {199'd0, busy}, 200'd0);
`ifdef MATRIX_LOADER_DET_CAPTURE_EN
    check("async_rst_det", {168'd0, det_out}, 200'd0);
`endif
    tick();
    rst = 1'b0;
    tick();
    check("sb_drained", 200'(exp_q.size()), 200'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
